// File: rtl/ex_stage_pipe_if.sv
// ID -> EX instruction bus, later-stage forwarding taps and EX -> MEM result bus.
// master drives the instruction side (ID stage), slave is the execute stage.
interface ex_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  logic              in_valid;
  logic              flush;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   reg1;
  logic [XLEN-1:0]   reg2;
  logic [XLEN-1:0]   offset;
  logic [RADDR-1:0]  rs_src;
  logic [RADDR-1:0]  rt_src;
  logic [RADDR-1:0]  rt;
  logic [RADDR-1:0]  rd;
  logic              RegDest;
  logic              ALUSrc;
  logic              Branch;
  logic              MemRead;
  logic              MemWrite;
  logic              RegWrite;
  logic              MemtoReg;
  logic [1:0]        ALUOp;

  logic              exmem_regwrite;
  logic              memwb_regwrite;
  logic [RADDR-1:0]  exmem_rd;
  logic [RADDR-1:0]  memwb_rd;
  logic [XLEN-1:0]   exmem_value;
  logic [XLEN-1:0]   memwb_value;

  logic              stall_out;
  logic              out_valid;
  logic [XLEN-1:0]   brachAdr;
  logic [XLEN-1:0]   ALUres;
  logic [XLEN-1:0]   reg21;
  logic [RADDR-1:0]  writeReg;
  logic              zero;
  logic              BranchOut;
  logic              MemReadOut;
  logic              MemWriteOut;
  logic              RegWriteOut;
  logic              MemtoRegOut;

  modport master (
    output in_valid, flush, pc, reg1, reg2, offset, rs_src, rt_src, rt, rd,
           RegDest, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, ALUOp,
           exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd, exmem_value, memwb_value,
    input  stall_out, out_valid, brachAdr, ALUres, reg21, writeReg, zero,
           BranchOut, MemReadOut, MemWriteOut, RegWriteOut, MemtoRegOut
  );

  modport slave (
    input  in_valid, flush, pc, reg1, reg2, offset, rs_src, rt_src, rt, rd,
           RegDest, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, ALUOp,
           exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd, exmem_value, memwb_value,
    output stall_out, out_valid, brachAdr, ALUres, reg21, writeReg, zero,
           BranchOut, MemReadOut, MemWriteOut, RegWriteOut, MemtoRegOut
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// MIPS execute stage: ID/EX register, operand forwarding, ALU, branch target,
// and a multi-cycle signed MULT unit with HI/LO that stalls the front end.
module ex_stage_pipe #(
  parameter int XLEN    = 32,
  parameter int RADDR   = 5,
  parameter int MUL_LAT = 4
) (
  input logic            clock,
  input logic            reset,
  ex_stage_pipe_if.slave bus
);

  localparam int CW    = $clog2(MUL_LAT + 1);
  localparam int LOADV = (MUL_LAT >= 2) ? (MUL_LAT - 2) : 0;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t state, state_n;

  // ID/EX pipeline register
  logic              q_valid;
  logic [XLEN-1:0]   q_pc, q_reg1, q_reg2, q_off;
  logic [RADDR-1:0]  q_rs, q_rtsrc, q_rt, q_rd;
  logic              q_regdest, q_alusrc, q_branch, q_memread, q_memwrite;
  logic              q_regwrite, q_memtoreg;
  logic [1:0]        q_aluop;

  logic              stall;
  logic              start;
  logic              hilo_we;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   op_a, op_b;
  logic [XLEN-1:0]   hi, lo;

  logic [XLEN-1:0]   fwd_a, fwd_b, alu_b, alu_res;
  logic              funct_ok;
  logic [5:0]        funct;
  logic              is_mult;
  logic [XLEN-1:0]   mul_a, mul_b;
  logic signed [2*XLEN-1:0] product;
  logic              valid_out, ctrl_en;
  logic [XLEN-1:0]   res_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid    <= 1'b0;
      q_pc       <= '0;
      q_reg1     <= '0;
      q_reg2     <= '0;
      q_off      <= '0;
      q_rs       <= '0;
      q_rtsrc    <= '0;
      q_rt       <= '0;
      q_rd       <= '0;
      q_regdest  <= 1'b0;
      q_alusrc   <= 1'b0;
      q_branch   <= 1'b0;
      q_memread  <= 1'b0;
      q_memwrite <= 1'b0;
      q_regwrite <= 1'b0;
      q_memtoreg <= 1'b0;
      q_aluop    <= '0;
    end else if (!stall) begin
      q_valid    <= bus.in_valid & ~bus.flush;
      q_pc       <= bus.pc;
      q_reg1     <= bus.reg1;
      q_reg2     <= bus.reg2;
      q_off      <= bus.offset;
      q_rs       <= bus.rs_src;
      q_rtsrc    <= bus.rt_src;
      q_rt       <= bus.rt;
      q_rd       <= bus.rd;
      q_regdest  <= bus.RegDest;
      q_alusrc   <= bus.ALUSrc;
      q_branch   <= bus.Branch;
      q_memread  <= bus.MemRead;
      q_memwrite <= bus.MemWrite;
      q_regwrite <= bus.RegWrite;
      q_memtoreg <= bus.MemtoReg;
      q_aluop    <= bus.ALUOp;
    end
  end

  // EX/MEM wins over MEM/WB; $0 is never forwarded
  always_comb begin
    fwd_a = q_reg1;
    if (bus.exmem_regwrite && (q_rs != '0) && (bus.exmem_rd == q_rs))
      fwd_a = bus.exmem_value;
    else if (bus.memwb_regwrite && (q_rs != '0) && (bus.memwb_rd == q_rs))
      fwd_a = bus.memwb_value;

    fwd_b = q_reg2;
    if (bus.exmem_regwrite && (q_rtsrc != '0) && (bus.exmem_rd == q_rtsrc))
      fwd_b = bus.exmem_value;
    else if (bus.memwb_regwrite && (q_rtsrc != '0) && (bus.memwb_rd == q_rtsrc))
      fwd_b = bus.memwb_value;
  end

  assign funct   = q_off[5:0];
  assign is_mult = q_valid && (q_aluop == 2'b10) && (funct == 6'h18);
  assign alu_b   = q_alusrc ? q_off : fwd_b;

  always_comb begin
    alu_res  = '0;
    funct_ok = 1'b1;
    unique case (q_aluop)
      2'b00: alu_res = fwd_a + alu_b;
      2'b01: alu_res = fwd_a - alu_b;
      2'b11: alu_res = fwd_a | alu_b;
      2'b10: begin
        case (funct)
          6'h20:   alu_res = fwd_a + alu_b;
          6'h22:   alu_res = fwd_a - alu_b;
          6'h24:   alu_res = fwd_a & alu_b;
          6'h25:   alu_res = fwd_a | alu_b;
          6'h2A:   alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
          6'h18:   alu_res = '0;
          6'h10:   alu_res = hi;
          6'h12:   alu_res = lo;
          default: funct_ok = 1'b0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // The entry cycle in IDLE counts toward MUL_LAT, so MUL runs MUL_LAT-1 cycles.
  always_comb begin
    state_n = state;
    stall   = 1'b0;
    start   = 1'b0;
    hilo_we = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (is_mult) begin
          stall = 1'b1;
          start = 1'b1;
          if (MUL_LAT == 1) begin
            hilo_we = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_MUL;
          end
        end
      end
      S_MUL: begin
        stall = 1'b1;
        if (cnt == '0) begin
          hilo_we = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign mul_a   = (state == S_IDLE) ? fwd_a : op_a;
  assign mul_b   = (state == S_IDLE) ? fwd_b : op_b;
  assign product = $signed({{XLEN{mul_a[XLEN-1]}}, mul_a}) *
                   $signed({{XLEN{mul_b[XLEN-1]}}, mul_b});

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      op_a <= '0;
      op_b <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (start) begin
        op_a <= fwd_a;
        op_b <= fwd_b;
        cnt  <= CW'(LOADV);
      end else if ((state == S_MUL) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (hilo_we) begin
        hi <= product[2*XLEN-1:XLEN];
        lo <= product[XLEN-1:0];
      end
    end
  end

  assign valid_out = (state == S_DONE) || ((state == S_IDLE) && q_valid && !is_mult);
  assign ctrl_en   = valid_out && (state != S_DONE);
  assign res_out   = (state == S_DONE) ? '0 : alu_res;

  assign bus.stall_out   = stall;
  assign bus.out_valid   = valid_out;
  assign bus.ALUres      = res_out;
  assign bus.zero        = valid_out && (res_out == '0);
  assign bus.brachAdr    = q_pc + (q_off << 2);
  assign bus.reg21       = fwd_b;
  assign bus.writeReg    = q_regdest ? q_rd : q_rt;
  assign bus.BranchOut   = ctrl_en & q_branch;
  assign bus.MemReadOut  = ctrl_en & q_memread;
  assign bus.MemWriteOut = ctrl_en & q_memwrite;
  assign bus.RegWriteOut = ctrl_en & q_regwrite & funct_ok;
  assign bus.MemtoRegOut = ctrl_en & q_memtoreg;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed vectors, a transaction-level model checked
// every cycle, and hand-computed literal expectations.
module tb_ex_stage_pipe;
  localparam int XLEN    = 32;
  localparam int RADDR   = 5;
  localparam int MUL_LAT = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ex_stage_pipe_if #(.XLEN(XLEN), .RADDR(RADDR)) bus ();
  ex_stage_pipe #(.XLEN(XLEN), .RADDR(RADDR), .MUL_LAT(MUL_LAT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc, r1, r2, off;
    logic [4:0]  rs, rts, rt, rd;
    logic        regdest, alusrc, branch, memread, memwrite, regwrite, memtoreg;
    logic [1:0]  aluop;
  } ins_t;

  typedef struct {
    logic        stall, ov, br, mr, mw, rw, m2r, zero;
    logic [31:0] alu, badr, r21;
    logic [4:0]  wreg;
  } exp_t;

  int total, bad;
  bit run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ins_t nop();
    ins_t i;
    i.pc = '0; i.r1 = '0; i.r2 = '0; i.off = '0;
    i.rs = '0; i.rts = '0; i.rt = '0; i.rd = '0;
    i.regdest = 0; i.alusrc = 0; i.branch = 0; i.memread = 0;
    i.memwrite = 0; i.regwrite = 0; i.memtoreg = 0; i.aluop = '0;
    return i;
  endfunction

  function automatic ins_t rtype(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rs, input logic [4:0] rts, input logic [4:0] rd);
    ins_t i = nop();
    i.aluop = 2'b10; i.off = {26'd0, fn}; i.r1 = a; i.r2 = b;
    i.rs = rs; i.rts = rts; i.rt = rts; i.rd = rd; i.regdest = 1; i.regwrite = 1;
    return i;
  endfunction

  task automatic drive(input ins_t i, input logic v, input logic f);
    bus.in_valid = v;  bus.flush = f;
    bus.pc = i.pc;     bus.reg1 = i.r1;   bus.reg2 = i.r2;  bus.offset = i.off;
    bus.rs_src = i.rs; bus.rt_src = i.rts; bus.rt = i.rt;  bus.rd = i.rd;
    bus.RegDest = i.regdest; bus.ALUSrc = i.alusrc; bus.Branch = i.branch;
    bus.MemRead = i.memread; bus.MemWrite = i.memwrite; bus.RegWrite = i.regwrite;
    bus.MemtoReg = i.memtoreg; bus.ALUOp = i.aluop;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ev,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mv);
    bus.exmem_regwrite = ew; bus.exmem_rd = erd; bus.exmem_value = ev;
    bus.memwb_regwrite = mw; bus.memwb_rd = mrd; bus.memwb_value = mv;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  logic        m_valid;
  ins_t        m_i;
  logic [31:0] m_hi, m_lo;
  int          m_busy;
  bit          m_done;
  longint      m_prod, sa, sb;
  exp_t        e_now, e_cmp;

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] v);
    if (src != 0 && bus.exmem_regwrite && bus.exmem_rd == src) return bus.exmem_value;
    if (src != 0 && bus.memwb_regwrite && bus.memwb_rd == src) return bus.memwb_value;
    return v;
  endfunction

  function automatic bit model_is_mult();
    return m_valid && m_i.aluop == 2'b10 && m_i.off[5:0] == 6'h18;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [31:0] a, bf, b, res;
    logic ok;
    e = '{default: '0};
    a  = fwd(m_i.rs, m_i.r1);
    bf = fwd(m_i.rts, m_i.r2);
    b  = m_i.alusrc ? m_i.off : bf;
    res = 32'd0;
    ok  = 1'b1;
    case (m_i.aluop)
      2'd0: res = a + b;
      2'd1: res = a - b;
      2'd3: res = a | b;
      default: begin
        case (m_i.off[5:0])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h18: res = 32'd0;
          6'h10: res = m_hi;
          6'h12: res = m_lo;
          default: ok = 1'b0;
        endcase
      end
    endcase
    e.badr = m_i.pc + (m_i.off << 2);
    e.r21  = bf;
    e.wreg = m_i.regdest ? m_i.rd : m_i.rt;
    if (m_done) begin
      e.ov = 1'b1;
      e.alu = 32'd0;
    end else if (m_busy > 0 || model_is_mult()) begin
      e.stall = 1'b1;
      e.alu = res;
    end else begin
      e.ov  = m_valid;
      e.alu = res;
      e.br  = m_valid & m_i.branch;
      e.mr  = m_valid & m_i.memread;
      e.mw  = m_valid & m_i.memwrite;
      e.rw  = m_valid & m_i.regwrite & ok;
      e.m2r = m_valid & m_i.memtoreg;
    end
    e.zero = e.ov && (e.alu == 32'd0);
    return e;
  endfunction

  function automatic ins_t sample_inputs();
    ins_t i;
    i.pc = bus.pc; i.r1 = bus.reg1; i.r2 = bus.reg2; i.off = bus.offset;
    i.rs = bus.rs_src; i.rts = bus.rt_src; i.rt = bus.rt; i.rd = bus.rd;
    i.regdest = bus.RegDest; i.alusrc = bus.ALUSrc; i.branch = bus.Branch;
    i.memread = bus.MemRead; i.memwrite = bus.MemWrite; i.regwrite = bus.RegWrite;
    i.memtoreg = bus.MemtoReg; i.aluop = bus.ALUOp;
    return i;
  endfunction

  always @(posedge clock) begin
    e_now = model_out();
    if (reset) begin
      m_valid = 1'b0; m_i = nop(); m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0;
    end else begin
      if (m_done) begin
        m_done = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_hi = m_prod[63:32]; m_lo = m_prod[31:0]; m_done = 1;
        end
      end else if (model_is_mult()) begin
        sa = longint'($signed(fwd(m_i.rs, m_i.r1)));
        sb = longint'($signed(fwd(m_i.rts, m_i.r2)));
        m_prod = sa * sb;
        m_busy = MUL_LAT - 1;
        if (m_busy == 0) begin
          m_hi = m_prod[63:32]; m_lo = m_prod[31:0]; m_done = 1;
        end
      end
      if (!e_now.stall) begin
        m_valid = bus.in_valid & ~bus.flush;
        m_i = sample_inputs();
      end
    end
  end

  always @(negedge clock) begin
    if (run && !reset) begin
      e_cmp = model_out();
      chkb("m_stall", bus.stall_out, e_cmp.stall);
      chkb("m_valid", bus.out_valid, e_cmp.ov);
      chkb("m_branch", bus.BranchOut, e_cmp.br);
      chkb("m_memread", bus.MemReadOut, e_cmp.mr);
      chkb("m_memwrite", bus.MemWriteOut, e_cmp.mw);
      chkb("m_regwrite", bus.RegWriteOut, e_cmp.rw);
      chkb("m_memtoreg", bus.MemtoRegOut, e_cmp.m2r);
      chkb("m_zero", bus.zero, e_cmp.zero);
      if (e_cmp.ov) begin
        chk("m_alu", bus.ALUres, e_cmp.alu);
        chk("m_badr", bus.brachAdr, e_cmp.badr);
        chk("m_reg21", bus.reg21, e_cmp.r21);
        chk("m_wreg", {27'd0, bus.writeReg}, {27'd0, e_cmp.wreg});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    ins_t ins;
    int   nstall;
    total = 0; bad = 0; run = 0;

    reset = 1'b1;
    repeat (2) begin
      bus.in_valid = 1'($urandom); bus.flush = 1'($urandom);
      bus.pc = $urandom; bus.reg1 = $urandom; bus.reg2 = $urandom; bus.offset = $urandom;
      bus.rs_src = 5'($urandom); bus.rt_src = 5'($urandom); bus.rt = 5'($urandom); bus.rd = 5'($urandom);
      bus.RegDest = 1'($urandom); bus.ALUSrc = 1'($urandom); bus.Branch = 1'($urandom);
      bus.MemRead = 1'($urandom); bus.MemWrite = 1'($urandom); bus.RegWrite = 1'($urandom);
      bus.MemtoReg = 1'($urandom); bus.ALUOp = 2'($urandom);
      set_fwd(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      tick();
    end
    reset = 1'b0;
    drive(nop(), 1'b0, 1'b0);
    set_fwd(0, 0, 0, 0, 0, 0);
    run = 1;
    @(negedge clock);
    chkb("rst_valid", bus.out_valid, 1'b0);
    chkb("rst_stall", bus.stall_out, 1'b0);
    chkb("rst_regwrite", bus.RegWriteOut, 1'b0);
    chkb("rst_branch", bus.BranchOut, 1'b0);
    chkb("rst_zero", bus.zero, 1'b0);
    chk("rst_alu", bus.ALUres, 32'd0);

    // branch target and sub-equal
    ins = nop(); ins.pc = 32'h100; ins.off = 32'h3; ins.branch = 1; ins.aluop = 2'b01;
    ins.r1 = 7; ins.r2 = 7; ins.rs = 1; ins.rts = 2;
    drive(ins, 1, 0); tick(); drive(nop(), 0, 0);
    @(negedge clock);
    chk("br_adr", bus.brachAdr, 32'h10C);
    chkb("br_zero", bus.zero, 1'b1);
    chk("br_alu", bus.ALUres, 32'd0);
    chkb("br_out", bus.BranchOut, 1'b1);

    // forwarding: EX/MEM priority, $0 never forwarded, MEM/WB only, rt forwarding
    ins = nop(); ins.aluop = 2'b00; ins.r1 = 1; ins.r2 = 2; ins.rs = 5; ins.rts = 6;
    ins.rd = 7; ins.regdest = 1; ins.regwrite = 1;
    drive(ins, 1, 0); tick(); set_fwd(1, 5, 32'h20, 1, 5, 32'h30);
    ins.rs = 0; drive(ins, 1, 0);
    @(negedge clock);
    chk("fwd_exmem", bus.ALUres, 32'h22);
    chk("fwd_wreg", {27'd0, bus.writeReg}, 32'd7);
    tick(); set_fwd(1, 5, 32'h20, 1, 5, 32'h30);
    ins.rs = 5; drive(ins, 1, 0);
    @(negedge clock);
    chk("fwd_r0", bus.ALUres, 32'd3);
    tick(); set_fwd(0, 5, 32'h20, 1, 5, 32'h30);
    drive(ins, 1, 0);
    @(negedge clock);
    chk("fwd_memwb", bus.ALUres, 32'h32);
    tick(); set_fwd(1, 6, 32'h40, 1, 5, 32'h30);
    drive(rtype(6'h2A, 32'hFFFF_FFFF, 32'd1, 3, 4, 9), 1, 0);
    @(negedge clock);
    chk("fwd_both", bus.ALUres, 32'h70);
    chk("fwd_reg21", bus.reg21, 32'h40);

    // funct decode: slt, and, invalid funct, immediate operand
    tick(); set_fwd(0, 0, 0, 0, 0, 0);
    drive(rtype(6'h24, 32'h0000_F0F0, 32'h0000_FF00, 3, 4, 9), 1, 0);
    @(negedge clock);
    chk("slt_signed", bus.ALUres, 32'd1);
    tick();
    drive(rtype(6'h3F, 32'd5, 32'd6, 3, 4, 9), 1, 0);
    @(negedge clock);
    chk("and", bus.ALUres, 32'h0000_F000);
    tick();
    ins = nop(); ins.aluop = 2'b00; ins.alusrc = 1; ins.r1 = 32'h10; ins.off = 32'hFFFF_FFFC;
    ins.pc = 32'h200; ins.memread = 1; ins.memtoreg = 1; ins.regwrite = 1; ins.rt = 8; ins.rs = 2;
    drive(ins, 1, 0);
    @(negedge clock);
    chkb("badfn_valid", bus.out_valid, 1'b1);
    chkb("badfn_regwrite", bus.RegWriteOut, 1'b0);
    chk("badfn_alu", bus.ALUres, 32'd0);
    tick();
    ins = nop(); ins.regwrite = 1; ins.memwrite = 1; ins.r1 = 3;
    drive(ins, 1, 1);
    @(negedge clock);
    chk("imm_alu", bus.ALUres, 32'hC);
    chk("imm_badr", bus.brachAdr, 32'h1F0);
    chkb("imm_memread", bus.MemReadOut, 1'b1);
    tick(); drive(nop(), 0, 0);
    @(negedge clock);
    chkb("flush_valid", bus.out_valid, 1'b0);
    chkb("flush_regwrite", bus.RegWriteOut, 1'b0);

    // multiply -3 * 7, then mflo / mfhi back-to-back
    tick();
    drive(rtype(6'h18, 32'hFFFF_FFFD, 32'd7, 1, 2, 0), 1, 0);
    tick();
    drive(rtype(6'h12, 0, 0, 0, 0, 10), 1, 1);
    nstall = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (!bus.stall_out) break;
      nstall++;
      tick();
      bus.flush = 1'b0;
    end
    chk("mul_stall_cycles", nstall, 32'd4);
    chkb("mul_done_valid", bus.out_valid, 1'b1);
    chk("mul_done_alu", bus.ALUres, 32'd0);
    chkb("mul_done_regwrite", bus.RegWriteOut, 1'b0);
    tick();
    drive(rtype(6'h10, 0, 0, 0, 0, 11), 1, 0);
    @(negedge clock);
    chk("mflo", bus.ALUres, 32'hFFFF_FFEB);
    tick(); drive(nop(), 0, 0);
    @(negedge clock);
    chk("mfhi", bus.ALUres, 32'hFFFF_FFFF);

    // reset during the second MUL cycle aborts the multiply
    tick();
    drive(rtype(6'h18, 32'd5, 32'd9, 1, 2, 0), 1, 0);
    tick(); drive(nop(), 0, 0);
    tick();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    drive(rtype(6'h12, 0, 0, 0, 0, 10), 1, 0);
    @(negedge clock);
    chkb("rstmul_stall", bus.stall_out, 1'b0);
    chkb("rstmul_valid", bus.out_valid, 1'b0);
    tick(); drive(nop(), 0, 0);
    @(negedge clock);
    chkb("rstmul_mflo_valid", bus.out_valid, 1'b1);
    chk("rstmul_mflo", bus.ALUres, 32'd0);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
